// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//
// Avalon-MM master that programs and services the interval timer used by the
// SS-OCT acquisition path, in place of CPU-driven timer servicing.
//   - cfg_start (in IDLE) latches cfg_period / cfg_count, writes the period
//     halves, then starts the timer in continuous mode with its irq enabled.
//   - Each timer irq is acknowledged by a status write; tick pulses and
//     tick_count (saturating) advances.
//   - After cfg_count ticks (0 = forever) or on cfg_stop, the timer is stopped,
//     any pending irq is cleared and done pulses.
//   - snap_req latches the timer counter and reads it back into snap_value.
//
// Ports
//   clk, reset_n             clock, async active-low reset
//   cfg_start/period/count   sequence start request and its configuration
//   cfg_stop                 stop request (deferred if not in RUN)
//   snap_req                 counter snapshot request (RUN or IDLE only)
//   busy, tick, done         status: not idle / timeout serviced / sequence end
//   tick_count               ticks serviced since last start, saturating
//   snap_value, snap_valid   last captured counter, 1-cycle update strobe
//   tmr_*                    Avalon-MM master to the timer slave (registered)
// ---------------------------------------------------------------------------
module timer_sequencer #(
    parameter int          CNT_W     = 16,
    parameter logic [15:0] CTRL_RUN  = 16'h0007,
    parameter logic [15:0] CTRL_STOP = 16'h0008
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_period,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_stop,
    input  logic             snap_req,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] tick_count,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
);

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_CONTROL  = 3'd1;
    localparam logic [2:0] A_PERIOD_L = 3'd2;
    localparam logic [2:0] A_PERIOD_H = 3'd3;
    localparam logic [2:0] A_SNAP_L   = 3'd4;
    localparam logic [2:0] A_SNAP_H   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR_STS,
        S_WR_STOP,
        S_CLR_FIN,
        S_SNAP_WR,
        S_SNAP_RL,
        S_SNAP_RH,
        S_SNAP_CAP
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      period_q;
    logic [CNT_W-1:0] count_q;
    logic             stop_pending;
    logic             snap_from_run;
    logic [15:0]      snap_lo;
    logic             limit_hit;

    logic             bus_cs;
    logic             bus_wn;
    logic [2:0]       bus_addr;
    logic [15:0]      bus_wd;

    // tick_count already holds the incremented value while in CLR_STS.
    assign limit_hit = (count_q != '0) && (tick_count == count_q);
    assign busy      = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start)     state_nxt = S_WR_PL;
                else if (snap_req) state_nxt = S_SNAP_WR;
            end
            S_WR_PL:   state_nxt = S_WR_PH;
            S_WR_PH:   state_nxt = S_WR_CTRL;
            S_WR_CTRL: state_nxt = S_RUN;
            S_RUN: begin
                if (stop_pending || cfg_stop) state_nxt = S_WR_STOP;
                else if (tmr_irq)             state_nxt = S_CLR_STS;
                else if (snap_req)            state_nxt = S_SNAP_WR;
            end
            S_CLR_STS:  state_nxt = limit_hit ? S_WR_STOP : S_RUN;
            S_WR_STOP:  state_nxt = S_CLR_FIN;
            S_CLR_FIN:  state_nxt = S_IDLE;
            S_SNAP_WR:  state_nxt = S_SNAP_RL;
            S_SNAP_RL:  state_nxt = S_SNAP_RH;
            S_SNAP_RH:  state_nxt = S_SNAP_CAP;
            S_SNAP_CAP: state_nxt = snap_from_run ? S_RUN : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus cycle for the state being entered. Registering these makes the
    // access appear on the bus during the cycle the FSM sits in that state.
    // ------------------------------------------------------------------
    always_comb begin
        bus_cs   = 1'b0;
        bus_wn   = 1'b1;
        bus_addr = A_STATUS;
        bus_wd   = 16'h0000;
        case (state_nxt)
            S_WR_PL: begin
                // WR_PL is only entered from IDLE, before period_q is loaded.
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_PERIOD_L;
                bus_wd   = cfg_period[15:0];
            end
            S_WR_PH: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_PERIOD_H;
                bus_wd   = period_q[31:16];
            end
            S_WR_CTRL: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_CONTROL;
                bus_wd   = CTRL_RUN;
            end
            S_WR_STOP: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_CONTROL;
                bus_wd   = CTRL_STOP;
            end
            S_CLR_STS, S_CLR_FIN: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_STATUS;
            end
            S_SNAP_WR: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = A_SNAP_L;
            end
            S_SNAP_RL: begin
                bus_cs   = 1'b1;
                bus_addr = A_SNAP_L;
            end
            S_SNAP_RH: begin
                bus_cs   = 1'b1;
                bus_addr = A_SNAP_H;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'h0000;
        end else begin
            tmr_chipselect <= bus_cs;
            tmr_write_n    <= bus_wn;
            tmr_address    <= bus_addr;
            tmr_writedata  <= bus_wd;
        end
    end

    // ------------------------------------------------------------------
    // Sequence configuration, tick accounting and stop deferral
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= 32'h0;
            count_q      <= '0;
            tick_count   <= '0;
            tick         <= 1'b0;
            done         <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            tick <= (state_nxt == S_CLR_STS);
            done <= (state == S_CLR_FIN);

            if (state == S_IDLE && cfg_start) begin
                period_q   <= cfg_period;
                count_q    <= cfg_count;
                tick_count <= '0;
            end else if (state_nxt == S_CLR_STS && tick_count != '1) begin
                tick_count <= tick_count + CNT_W'(1);
            end

            // A stop seen outside RUN is held until RUN is re-entered; it is
            // consumed by entering WR_STOP and never survives into IDLE.
            if (state_nxt == S_WR_STOP || state_nxt == S_IDLE)
                stop_pending <= 1'b0;
            else if (cfg_stop && state != S_RUN && state != S_IDLE)
                stop_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: readdata lags the address by one cycle, so the low half is
    // on the bus during SNAP_RH and the high half during SNAP_CAP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_from_run <= 1'b0;
            snap_lo       <= 16'h0000;
            snap_value    <= 32'h0;
            snap_valid    <= 1'b0;
        end else begin
            snap_valid <= (state == S_SNAP_CAP);
            if (state_nxt == S_SNAP_WR)
                snap_from_run <= (state == S_RUN);
            if (state == S_SNAP_RH)
                snap_lo <= tmr_readdata;
            if (state == S_SNAP_CAP)
                snap_value <= {tmr_readdata, snap_lo};
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timer_sequencer
//
// Drives timer_sequencer against a behavioural interval-timer slave. Bus
// traffic, tick/done/snap strobes are logged by a monitor; after each
// sequence the log is compared with the transaction list implied by the
// sequence rules (period writes, start, one status clear per tick, stop,
// final clear), with snapshot triplets checked and removed separately.
// ---------------------------------------------------------------------------
module tb_timer_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [31:0]      cfg_period = 32'h0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             cfg_stop = 1'b0;
    logic             snap_req = 1'b0;
    logic             busy, tick, done, snap_valid;
    logic [CNT_W-1:0] tick_count;
    logic [31:0]      snap_value;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect, tmr_write_n;
    logic [15:0]      tmr_writedata, tmr_readdata;
    logic             tmr_irq;

    always #5 clk = ~clk;

    timer_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .cfg_stop(cfg_stop), .snap_req(snap_req),
        .busy(busy), .tick(tick), .done(done), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
    );

    // ---------------- interval timer slave model ----------------
    logic [15:0] m_per_l, m_per_h, m_rd;
    logic [31:0] m_cnt, m_snap;
    logic        m_run, m_to, m_ito;
    logic        preset_en = 1'b0;
    logic [31:0] preset_val = 32'h0;

    assign tmr_irq      = m_to & m_ito;
    assign tmr_readdata = m_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_per_l <= 0; m_per_h <= 0; m_rd <= 0; m_cnt <= 0; m_snap <= 0;
            m_run <= 0; m_to <= 0; m_ito <= 0;
        end else begin
            m_rd <= 16'h0;
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito <= tmr_writedata[0];
                        if (tmr_writedata[3]) m_run <= 1'b0;
                        else if (tmr_writedata[2]) begin
                            m_run <= 1'b1;
                            m_cnt <= {m_per_h, m_per_l};
                        end
                    end
                    3'd2: m_per_l <= tmr_writedata;
                    3'd3: m_per_h <= tmr_writedata;
                    3'd4: m_snap  <= m_cnt;
                    default: ;
                endcase
            end
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_cnt <= {m_per_h, m_per_l};
                    m_to  <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (tmr_chipselect && tmr_write_n)
                m_rd <= (tmr_address == 3'd4) ? m_snap[15:0] :
                        (tmr_address == 3'd5) ? m_snap[31:16] : 16'h0;
            if (preset_en) m_cnt <= preset_val;
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        bit        wr;
        bit [2:0]  a;
        bit [15:0] d;
        int        cyc;
    } txn_t;

    txn_t        tq[$];
    int          tick_cyc[$];
    int          cyc = 0;
    int          tick_cnt = 0, done_cnt = 0, sv_cnt = 0, tick_bad = 0;
    int          start_cyc = 0, ctrl_cyc = 0;
    logic [31:0] sv_last = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr_chipselect)
                tq.push_back('{wr: !tmr_write_n, a: tmr_address, d: tmr_writedata, cyc: cyc});
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata == 16'h0007)
                ctrl_cyc = cyc;
            if (cfg_start && !busy) start_cyc = cyc;
            if (tick) begin
                tick_cnt++;
                tick_cyc.push_back(cyc);
                if (!(tmr_chipselect && !tmr_write_n && tmr_address == 3'd0 && tmr_writedata == 16'h0))
                    tick_bad++;
            end
            if (done) done_cnt++;
            if (snap_valid) begin
                sv_cnt++;
                sv_last = snap_value;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input bit wr, input bit [2:0] a, input bit [15:0] d);
        return {12'h0, wr, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one start..done sequence. stop_at > 0 issues cfg_stop once that many
    // ticks were seen; early issues cfg_stop during the period writes.
    task automatic run_seq(input logic [31:0] per, input int cnt, input bit snaps,
                           input int stop_at, input bit early);
        int   tq0 = tq.size();
        int   t0 = tick_cnt, d0 = done_cnt, s0 = sv_cnt, tc0 = tick_cyc.size(), tb0 = tick_bad;
        int   n_exp, budget, nsnap, lim, i;
        bit   stopped = 0;
        txn_t rest[$];
        txn_t ex[$];

        cfg_period = per;
        cfg_count  = CNT_W'(cnt);
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
        if (early) begin
            cfg_stop = 1'b1;
            step();
            cfg_stop = 1'b0;
            stopped  = 1;
        end
        chk("busy_run", 32'(busy), 32'd1);

        budget = 0;
        while (done_cnt == d0 && budget < 20000) begin
            snap_req  = 1'b0;
            cfg_stop  = 1'b0;
            cfg_start = 1'b0;
            if (busy) begin
                if (snaps && $urandom_range(0, 5) == 0) snap_req = 1'b1;
                if ($urandom_range(0, 15) == 0) begin
                    cfg_start  = 1'b1;
                    cfg_period = $urandom;
                end
                if (!stopped && stop_at > 0 && tick_cnt - t0 >= stop_at) begin
                    cfg_stop = 1'b1;
                    stopped  = 1;
                end
            end
            step();
            budget++;
        end
        snap_req = 1'b0; cfg_stop = 1'b0; cfg_start = 1'b0;
        chk("done_seen", (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) step();

        lim   = (1 << CNT_W) - 1;
        n_exp = early ? 0 : (stop_at > 0 ? stop_at : cnt);
        chk("ticks", tick_cnt - t0, n_exp);
        chk("done_once", done_cnt - d0, 1);
        chk("tick_count", 32'(tick_count), (n_exp > lim) ? lim : n_exp);
        chk("busy_end", 32'(busy), 32'd0);
        chk("tick_clr", tick_bad - tb0, 0);
        chk("ctrl_lat", ctrl_cyc - start_cyc, 3);

        // peel snapshot triplets out of the log
        nsnap = 0;
        i = tq0;
        while (i < tq.size()) begin
            if (tq[i].wr && tq[i].a == 3'd4) begin
                if (i + 2 < tq.size()) begin
                    chk("snap_rl", pk(tq[i+1].wr, tq[i+1].a, 16'h0), pk(0, 3'd4, 16'h0));
                    chk("snap_rh", pk(tq[i+2].wr, tq[i+2].a, 16'h0), pk(0, 3'd5, 16'h0));
                end else begin
                    chk("snap_trunc", i + 2, tq.size() - 1);
                end
                nsnap++;
                i += 3;
            end else begin
                rest.push_back(tq[i]);
                i++;
            end
        end
        chk("snap_cnt", sv_cnt - s0, nsnap);
        if (nsnap > 0) chk("snap_run_val", sv_last, m_snap);

        ex.push_back('{1, 3'd2, per[15:0], 0});
        ex.push_back('{1, 3'd3, per[31:16], 0});
        ex.push_back('{1, 3'd1, 16'h0007, 0});
        for (int k = 0; k < n_exp; k++) ex.push_back('{1, 3'd0, 16'h0, 0});
        ex.push_back('{1, 3'd1, 16'h0008, 0});
        ex.push_back('{1, 3'd0, 16'h0, 0});
        chk("txn_len", rest.size(), ex.size());
        for (int k = 0; k < ex.size() && k < rest.size(); k++)
            chk($sformatf("txn%0d", k), pk(rest[k].wr, rest[k].a, rest[k].d),
                pk(ex[k].wr, ex[k].a, ex[k].d));

        if (!snaps)
            for (int k = tc0 + 2; k < tick_cyc.size(); k++)
                chk("tick_ival", tick_cyc[k] - tick_cyc[k-1], per + 1);
    endtask

    // Snapshot from IDLE with the timer stopped and its counter preset.
    task automatic snap_idle(input logic [31:0] val);
        int tq0, s0, budget;
        preset_en  = 1'b1;
        preset_val = val;
        step();
        preset_en  = 1'b0;
        tq0 = tq.size();
        s0  = sv_cnt;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        budget = 0;
        while (sv_cnt == s0 && budget < 20) begin
            step();
            budget++;
        end
        chk("snap_seen", (sv_cnt != s0) ? 32'd1 : 32'd0, 32'd1);
        chk("snap_val", snap_value, val);
        repeat (3) step();
        chk("snap_pulse", sv_cnt - s0, 1);
        chk("snap_busy", 32'(busy), 32'd0);
        chk("snap_len", tq.size() - tq0, 3);
        if (tq.size() - tq0 == 3) begin
            chk("snap_w4", pk(tq[tq0].wr, tq[tq0].a, tq[tq0].d), pk(1, 3'd4, 16'h0));
            chk("snap_r4", pk(tq[tq0+1].wr, tq[tq0+1].a, 16'h0), pk(0, 3'd4, 16'h0));
            chk("snap_r5", pk(tq[tq0+2].wr, tq[tq0+2].a, 16'h0), pk(0, 3'd5, 16'h0));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {20'h0, busy, tick, done, snap_valid, tmr_chipselect, tmr_write_n, tmr_address},
            {20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        chk({tag, "_wd"}, 32'(tmr_writedata), 32'h0);
        chk({tag, "_tc"}, 32'(tick_count), 32'h0);
        chk({tag, "_sv"}, snap_value, 32'h0);
    endtask

    initial begin
        int stop_at, cnt;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        run_seq(32'h0001_E847, 3, 0, 0, 1);   // period writes, start latency, deferred stop
        run_seq(32'd20, 3, 0, 0, 0);          // auto-stop after 3 ticks
        run_seq(32'd15, 0, 0, 5, 0);          // run forever, stopped after 5
        run_seq(32'd10, 0, 0, 17, 0);         // tick_count saturates at 15

        snap_idle(32'h0012_3456);
        snap_idle($urandom);
        snap_idle($urandom);

        for (int r = 0; r < 6; r++) begin
            stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            cnt     = (stop_at > 0) ? 0 : $urandom_range(1, 5);
            run_seq($urandom_range(10, 30), cnt, 1'b1, stop_at, 1'b0);
        end

        // reset while writing period_h abandons the sequence
        cfg_period = 32'h0000_0020;
        cfg_count  = 4'd2;
        cfg_start  = 1'b1;
        step();
        cfg_start  = 1'b0;
        step();
        chk("mid_addr", 32'(tmr_address), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step();
        run_seq(32'd12, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Avalon-MM master that programs and services the system interval timer (16-bit data, 3-bit word address) for the SS-OCT acquisition path.
- On request, loads a 32-bit period, starts the timer in continuous mode with its interrupt enabled, and acknowledges each timeout by clearing status.
- Counts ticks and stops the timer after a programmed number of ticks.
- Supports an on-demand counter snapshot read.
- Sits between the acquisition control logic and the timer slave, replacing CPU-driven timer servicing.

Parameters:
CNT_W, 16, width of cfg_count and tick_count
CTRL_RUN, 16'h0007, control word written to start the timer (ITO=1, CONT=1, START=1)
CTRL_STOP, 16'h0008, control word written to stop the timer (STOP=1, ITO=0, CONT=0)

Ports:
clk  in  1  system clock
reset_n  in  1  reset
cfg_start  in  1  start request pulse; sampled only in IDLE
cfg_period  in  32  timer load value; interval = cfg_period+1 clk
cfg_count  in  CNT_W  ticks before auto-stop; 0 = run forever
cfg_stop  in  1  stop request pulse
snap_req  in  1  snapshot request pulse
busy  out  1  high whenever FSM is not IDLE
tick  out  1  1-cycle pulse per serviced timeout
done  out  1  1-cycle pulse when sequence ends (auto or stop)
tick_count  out  CNT_W  ticks serviced since last start, saturating
snap_value  out  32  last captured counter snapshot
snap_valid  out  1  1-cycle pulse when snap_value updates
tmr_address  out  3  timer word address
tmr_chipselect  out  1  timer select
tmr_write_n  out  1  timer write strobe, active low
tmr_writedata  out  16  timer write data
tmr_readdata  in  16  timer read data; registered, valid 1 cycle after address
tmr_irq  in  1  timer interrupt; level, held until status is written

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All outputs return to idle values: busy=0, tick=0, done=0, snap_valid=0, tick_count=0, snap_value=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. FSM goes to IDLE. Reset mid-sequence abandons the sequence; the timer shares the reset.
- Bus: the slave has no waitrequest, so every write completes in one cycle. All tmr_* outputs are registered. Outside access cycles: chipselect=0, write_n=1.
- Addresses: 0=status, 1=control, 2=period_l, 3=period_h, 4=snap_l, 5=snap_h.
- Start path: IDLE + cfg_start latches cfg_period and cfg_count, clears tick_count, then runs WR_PL -> WR_PH -> WR_CTRL -> RUN.
  - WR_PL: write addr 2 = period[15:0].
  - WR_PH: write addr 3 = period[31:16].
  - WR_CTRL: write addr 1 = CTRL_RUN.
  - Latency from cfg_start to the control write cycle is 3 clk.
- RUN: checks in priority order stop_pending or cfg_stop > tmr_irq > snap_req.
  - Stop: go to WR_STOP.
  - tmr_irq: go to CLR_STS, which writes addr 0 = 0, pulses tick, and increments tick_count (saturates at all-ones).
  - After CLR_STS: if cfg_count != 0 and the new tick_count == cfg_count, go to WR_STOP; otherwise return to RUN.
  - The control write is not re-issued on each tick.
- Stop path: WR_STOP writes addr 1 = CTRL_STOP, then CLR_FIN writes addr 0 = 0 to drop any pending irq, then done pulses and the FSM returns to IDLE.
- Snapshot: SNAP_WR writes addr 4 = 0, which latches the counter. Then:
  - SNAP_RL reads addr 4.
  - SNAP_RH reads addr 5 and captures readdata as the low half.
  - SNAP_CAP captures readdata as the high half; snap_value updates and snap_valid pulses the next cycle.
  - Afterwards the FSM returns to RUN.
  - snap_req in IDLE is serviced the same way and then returns to IDLE.
- Simultaneous events:
  - cfg_stop arriving in any non-RUN busy state sets stop_pending, serviced on the next RUN entry; it is ignored in IDLE.
  - tmr_irq asserted during a snapshot or any write is not lost, because it is level; it is serviced when RUN is re-entered.
  - snap_req not in RUN/IDLE is dropped.
  - cfg_start while busy is ignored.
  - irq and snap_req together: irq first; the snap is dropped unless it is still asserted.

Test Plan:
- Start, period 0x0001_E847, count 3 -> writes (2,0xE847), (3,0x0001), (1,0x0007) on 3 consecutive cycles; busy=1.
- Timer model fires irq every 125k clk, count=3 -> three tick pulses each followed by write (0,0); after the third, writes (1,0x0008), (0,0); done pulses; busy=0; tick_count=3.
- count=0, 5 irqs, then cfg_stop -> tick_count=5, stop writes issued, done pulses once.
- snap_req in RUN with model counter 0x0012_3456 -> write addr 4, reads 4 then 5; snap_value=0x0012_3456, snap_valid 1 cycle.
- irq asserted during SNAP_RL -> snapshot completes, then CLR_STS immediately follows; no tick is lost.
- reset_n low during WR_PH -> all outputs at reset values immediately; cfg_start after release restarts cleanly at WR_PL.
